cpu_phase_sequencer: RTL
========================

Name: cpu_phase_sequencer

Overview:
Multi-cycle phase controller for the single-cycle-derived core. It generates the 2-bit `state` phase code consumed by the register file and the other datapath blocks. It handshakes with instruction and data memory, gates PC update, IR load and write-back, and keeps cycle/retired-instruction counters. It sits at the top of the core, beside the decoder, and drives every block that takes a `state` input.

Parameters:
- CNT_W, 32, width of `cycle_cnt` and `instret_cnt`.
- TIMEOUT, 255, maximum wait cycles on `imem_ready`/`dmem_ready` before bus error (1..2^16-1).

Ports:
- clk  in  1  core clock; all flops on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level; leaves IDLE or HALT.
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_access  in  1  decoded instruction is load/store; sampled in EXECUTE.
- dmem_req  out  1  data memory request.
- dmem_ready  in  1  data access complete this cycle.
- halt_req  in  1  decoded ecall/ebreak; sampled in EXECUTE.
- state  out  2  phase code: 0 FETCH, 1 DECODE, 2 EXECUTE, 3 MEM/WB.
- ir_load  out  1  capture instruction word this edge.
- pc_en  out  1  advance PC this edge.
- wb_en  out  1  write-back enable (ANDed with decoder regwrite).
- busy  out  1  high in FETCH..WB.
- halted  out  1  high in HALT.
- bus_error  out  1  sticky memory timeout flag.
- cycle_cnt  out  CNT_W  busy cycles.
- instret_cnt  out  CNT_W  retired instructions.

Behaviour:
- Reset (async, rst_n low): FSM to IDLE. All 1-bit outputs 0, `state` = 0, both counters 0, wait timer 0. Reset mid-operation drops `imem_req`/`dmem_req` immediately; no partial retire.
- FSM states: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, HALT, ERROR.
- Outputs are decoded from the state register (Moore), except `ir_load`.
- `state` code per FSM state: IDLE, HALT, ERROR → 0 with `busy` = 0.
- IDLE: `start` = 1 → FETCH.
- FETCH: `imem_req` = 1.
  - `imem_ready` = 1 → `ir_load` = 1 in the same cycle (Mealy), next state DECODE.
  - Otherwise the wait timer increments. Timer reaching TIMEOUT → ERROR.
  - `imem_ready` in the expiry cycle wins over the timeout.
- DECODE: exactly 1 cycle with `state` = 1 (register-file read/write phase) → EXECUTE.
- EXECUTE: exactly 1 cycle.
  - `halt_req` = 1 → HALT; `instret_cnt`++ and `pc_en` = 1 this cycle.
  - Else `dmem_access` = 1 → MEM.
  - Else → WB.
  - `halt_req` has priority over `dmem_access`.
- MEM: `dmem_req` = 1, `state` = 3. `dmem_ready` → WB. Timeout rule is identical to FETCH.
- WB: 1 cycle, `state` = 3, `wb_en` = 1, `pc_en` = 1, `instret_cnt`++ → FETCH.
- HALT: `halted` = 1. `start` = 1 → FETCH, resuming at the already-advanced PC.
- ERROR: `bus_error` = 1. All requests low. Exits only on reset; `start` is ignored.
- Wait timer: cleared on every entry to FETCH and MEM; width is ceil(log2(TIMEOUT+1)).
- `cycle_cnt` increments every cycle `busy` = 1. Both counters wrap modulo 2^CNT_W with no saturation.
- Latency with zero-wait memory:
  - ALU instruction: 4 cycles (FETCH, DECODE, EXECUTE, WB).
  - Load/store: 5 cycles.
  - Each extra memory wait cycle adds 1.
- `imem_ready`/`dmem_ready` asserted outside their wait states are ignored.

Decomposition:
- Package `cpu_phase_pkg`:
  - Phase-code localparams PH_FETCH = 0, PH_DECODE = 1, PH_EXEC = 2, PH_MEMWB = 3.
  - FSM state encoding (3-bit).
  - Shared by register file, ALU and memory interface.
- Sub-module `mem_wait_timer`: counter with `clr`, `en` and `expired` output, parameterised by TIMEOUT. One instance, shared by FETCH and MEM.

Test Plan:
- ALU stream, zero-wait memory, `start` pulse, 3 instructions → `state` sequence 0,1,2,3 repeating; `instret_cnt` = 3 and `cycle_cnt` = 12 after the third WB.
- Load with `dmem_ready` delayed 2 cycles → MEM lasts 3 cycles; instruction takes 7 cycles; `wb_en` single pulse.
- `imem_ready` held low, TIMEOUT = 4 → ERROR after 4 FETCH wait cycles; `bus_error` = 1; `start` ignored; `rst_n` low clears it.
- `halt_req` and `dmem_access` both high in EXECUTE → HALT, no `dmem_req`; `halted` = 1; `start` resumes FETCH with `instret_cnt` +1.
- Assert `rst_n` low mid-MEM → same-cycle `dmem_req` = 0, counters 0, IDLE after release.
- Counter wrap with CNT_W = 4 → `cycle_cnt` reads 15 then 0.

Source files
------------

// File: rtl/cpu_phase_sequencer_pkg.sv
// Shared phase codes and sequencer state encoding for the multi-cycle core.
// The register file, ALU and memory interface decode `state` using PH_*.
package cpu_phase_pkg;

   localparam logic [1:0] PH_FETCH  = 2'd0;
   localparam logic [1:0] PH_DECODE = 2'd1;
   localparam logic [1:0] PH_EXEC   = 2'd2;
   localparam logic [1:0] PH_MEMWB  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_HALT   = 3'd6,
      ST_ERROR  = 3'd7
   } seq_state_t;

   // Phase code seen by the datapath; idle-type states report FETCH (0).
   function automatic logic [1:0] phase_of(seq_state_t s);
      case (s)
         ST_DECODE:     return PH_DECODE;
         ST_EXEC:       return PH_EXEC;
         ST_MEM, ST_WB: return PH_MEMWB;
         default:       return PH_FETCH;
      endcase
   endfunction

   // True for the states that make up an instruction in flight.
   function automatic logic is_busy(seq_state_t s);
      return (s == ST_FETCH) || (s == ST_DECODE) || (s == ST_EXEC) ||
             (s == ST_MEM)   || (s == ST_WB);
   endfunction

endpackage

// File: rtl/cpu_phase_sequencer_if.sv
// Instruction/data memory request-ready handshake between the sequencer
// (master) and the memory subsystem (slave).
interface cpu_phase_sequencer_if;

   logic imem_req;
   logic imem_ready;
   logic dmem_req;
   logic dmem_ready;

   modport master (output imem_req, output dmem_req,
                   input  imem_ready, input dmem_ready);

   modport slave  (input  imem_req, input dmem_req,
                   output imem_ready, output dmem_ready);

endinterface

// File: rtl/cpu_phase_sequencer_mem_wait_timer.sv
// Memory wait timer shared by FETCH and MEM. Counts wait cycles while `en`
// is high; `expired` flags the wait cycle on which the count reaches TIMEOUT.
module mem_wait_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] cnt;

   // Wait-cycle counter; clear dominates so every wait state starts from zero.
   // NOTE: sequential state uses <= so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= cnt + TW'(1);
   end

   assign expired = en && (cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Multi-cycle phase sequencer: walks FETCH/DECODE/EXECUTE/MEM/WB, handshakes
// with instruction and data memory, and keeps cycle/retire counters.
module cpu_phase_sequencer
   import cpu_phase_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   cpu_phase_sequencer_if.master mem,
   input  logic                dmem_access,
   input  logic                halt_req,
   output logic [1:0]          state,
   output logic                ir_load,
   output logic                pc_en,
   output logic                wb_en,
   output logic                busy,
   output logic                halted,
   output logic                bus_error,
   output logic [CNT_W-1:0]    cycle_cnt,
   output logic [CNT_W-1:0]    instret_cnt
);

   seq_state_t state_q, state_d;
   logic       wait_en, wait_clr, wait_expired;

   // Timer runs only while a wait state is stalled on memory; any other
   // state clears it, so each entry to FETCH or MEM starts a fresh budget.
   assign wait_en  = ((state_q == ST_FETCH) && !mem.imem_ready) ||
                     ((state_q == ST_MEM)   && !mem.dmem_ready);
   assign wait_clr = (state_q != ST_FETCH) && (state_q != ST_MEM);

   mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (wait_clr),
      .en      (wait_en),
      .expired (wait_expired)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; a ready in the expiry cycle beats the timeout.
   // NOTE: assigning a default first keeps this block free of latches.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_FETCH;
         ST_FETCH:  if (mem.imem_ready) state_d = ST_DECODE;
                    else if (wait_expired) state_d = ST_ERROR;
         ST_DECODE: state_d = ST_EXEC;
         ST_EXEC:   if (halt_req) state_d = ST_HALT;
                    else if (dmem_access) state_d = ST_MEM;
                    else state_d = ST_WB;
         ST_MEM:    if (mem.dmem_ready) state_d = ST_WB;
                    else if (wait_expired) state_d = ST_ERROR;
         ST_WB:     state_d = ST_FETCH;
         ST_HALT:   if (start) state_d = ST_FETCH;
         ST_ERROR:  state_d = ST_ERROR;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Output decode: Moore from the state register, except the capture strobe
   // and the halt-retire PC step, which depend on this cycle's inputs.
   always_comb begin
      state     = phase_of(state_q);
      busy      = is_busy(state_q);
      ir_load   = (state_q == ST_FETCH) && mem.imem_ready;
      wb_en     = (state_q == ST_WB);
      pc_en     = (state_q == ST_WB) || ((state_q == ST_EXEC) && halt_req);
      halted    = (state_q == ST_HALT);
      bus_error = (state_q == ST_ERROR);
   end

   assign mem.imem_req = (state_q == ST_FETCH);
   assign mem.dmem_req = (state_q == ST_MEM);

   // Busy-cycle and retire counters; an instruction retires exactly when the
   // PC advances. Both wrap freely.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
      end else begin
         if (busy)  cycle_cnt   <= cycle_cnt + CNT_W'(1);
         if (pc_en) instret_cnt <= instret_cnt + CNT_W'(1);
      end
   end

endmodule
